// File: rtl/cv32e40p_pkg.sv
// Shared types for the debug-entry checker: controller states, rule indices,
// watchdog states and small helpers for the violation recording logic.
package cv32e40p_pkg;

    typedef enum logic [4:0] {
        RESET,
        BOOT_SET,
        SLEEP,
        WAIT_SLEEP,
        FIRST_FETCH,
        DECODE,
        IRQ_TAKEN_ID,
        IRQ_TAKEN_IF,
        IRQ_FLUSH,
        IRQ_FLUSH_ELW,
        ELW_EXE,
        FLUSH_EX,
        FLUSH_WB,
        XRET_JUMP,
        DBG_TAKEN_ID,
        DBG_TAKEN_IF,
        DBG_FLUSH,
        DBG_WAIT_BRANCH,
        DECODE_HWLOOP
    } ctrl_state_e;

    localparam int unsigned DBG_CHK_NUM_RULES = 5;

    typedef enum logic [2:0] {
        DBG_CHK_R0 = 3'd0,
        DBG_CHK_R1 = 3'd1,
        DBG_CHK_R2 = 3'd2,
        DBG_CHK_R3 = 3'd3,
        DBG_CHK_R4 = 3'd4
    } dbg_chk_rule_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        EXPIRED = 2'd2
    } dbg_wdog_state_e;

    function automatic logic [2:0] dbg_chk_popcount(input logic [DBG_CHK_NUM_RULES-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < int'(DBG_CHK_NUM_RULES); i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    // Lowest set index wins when several rules trip in the same cycle.
    function automatic dbg_chk_rule_e dbg_chk_first_rule(input logic [DBG_CHK_NUM_RULES-1:0] v);
        dbg_chk_rule_e r;
        r = DBG_CHK_R0;
        for (int i = int'(DBG_CHK_NUM_RULES) - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = dbg_chk_rule_e'(i[2:0]);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cv32e40p_dbg_lat_watchdog.sv
// Bounded-wait watchdog: pulses expire_o once when a debug request stays
// pending for MAX_LAT cycles without the controller reaching a taken state.
module cv32e40p_dbg_lat_watchdog
    import cv32e40p_pkg::*;
#(
    parameter int unsigned MAX_LAT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    input  logic debug_req_entry_i,
    input  logic debug_mode_i,
    input  logic taken_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_LIMIT = CNT_W'(MAX_LAT);

    dbg_wdog_state_e  state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;

    assign cnt_inc = cnt_reg + CNT_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        expire_o   = 1'b0;
        if (!enable_i) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (debug_req_entry_i && !debug_mode_i) begin
                        // The first pending cycle already counts; a one-cycle budget expires at once.
                        if (MAX_LAT > 1) begin
                            state_next = PEND;
                            cnt_next   = CNT_W'(1);
                        end else if (!taken_i) begin
                            state_next = EXPIRED;
                            cnt_next   = CNT_W'(1);
                            expire_o   = 1'b1;
                        end
                    end
                end
                PEND: begin
                    if (taken_i || !debug_req_entry_i || debug_mode_i) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == LAT_LIMIT) begin
                            state_next = EXPIRED;
                            expire_o   = 1'b1;
                        end
                    end
                end
                EXPIRED: begin
                    if (!debug_req_entry_i || taken_i) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/cv32e40p_dbg_entry_checker.sv
// Run-time checker beside the controller: flags debug-state entries without a
// valid cause and debug requests left unserviced beyond MAX_LAT cycles.
module cv32e40p_dbg_entry_checker
    import cv32e40p_pkg::*;
#(
    parameter int unsigned                  MAX_LAT = 16,
    parameter int unsigned                  CNT_W   = 8,
    parameter logic [DBG_CHK_NUM_RULES-1:0] RULE_EN = 5'b11111
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic                         clear_i,
    input  ctrl_state_e                  ctrl_fsm_cs_i,
    input  logic                         debug_mode_i,
    input  logic                         debug_req_entry_i,
    input  logic                         trigger_match_i,
    input  logic                         ebrk_insn_i,
    input  logic                         ebrk_force_debug_mode_i,
    input  logic                         debug_force_wakeup_i,
    input  logic                         debug_single_step_i,
    input  logic                         data_load_event_i,
    input  logic                         data_err_i,
    output logic [DBG_CHK_NUM_RULES-1:0] viol_o,
    output logic                         first_viol_valid_o,
    output logic [2:0]                   first_viol_id_o,
    output logic [CNT_W-1:0]             viol_cnt_o
);

    localparam int unsigned SUM_W = ((CNT_W > 3) ? CNT_W : 3) + 1;
    localparam logic [SUM_W-1:0] CNT_SAT = SUM_W'({CNT_W{1'b1}});

    logic ebrk, in_id, in_if, in_flush, taken, r0_cause, expire;
    logic [DBG_CHK_NUM_RULES-1:0] rule_raw, rule_hit;

    logic [DBG_CHK_NUM_RULES-1:0] viol_reg, viol_next;
    logic                         first_valid_reg, first_valid_next;
    dbg_chk_rule_e                first_id_reg, first_id_next;
    logic [CNT_W-1:0]             cnt_reg, cnt_next, cnt_base;
    logic [SUM_W-1:0]             cnt_sum;

    assign ebrk     = ebrk_insn_i & ebrk_force_debug_mode_i;
    assign in_id    = (ctrl_fsm_cs_i == DBG_TAKEN_ID);
    assign in_if    = (ctrl_fsm_cs_i == DBG_TAKEN_IF);
    assign in_flush = (ctrl_fsm_cs_i == DBG_FLUSH);
    assign taken    = in_id | in_if;
    assign r0_cause = trigger_match_i | ebrk | debug_req_entry_i;

    assign rule_raw[0] = in_id & ~debug_mode_i & ~r0_cause;
    assign rule_raw[1] = in_if & ~(debug_force_wakeup_i | debug_single_step_i);
    assign rule_raw[2] = in_flush & ~data_err_i
                       & ~(debug_mode_i | r0_cause | data_load_event_i);
    assign rule_raw[3] = expire;
    // An ebreak that should have trapped normally but still landed in debug.
    assign rule_raw[4] = in_id & ebrk_insn_i & ~ebrk_force_debug_mode_i
                       & ~debug_mode_i & ~r0_cause;

    for (genvar gi = 0; gi < int'(DBG_CHK_NUM_RULES); gi++) begin : g_rule_mask
        assign rule_hit[gi] = enable_i & RULE_EN[gi] & rule_raw[gi];
    end

    cv32e40p_dbg_lat_watchdog #(
        .MAX_LAT (MAX_LAT)
    ) u_watchdog (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .enable_i          (enable_i),
        .debug_req_entry_i (debug_req_entry_i),
        .debug_mode_i      (debug_mode_i),
        .taken_i           (taken),
        .expire_o          (expire)
    );

    // Clear wipes history first, so a same-cycle violation is the only thing kept.
    always_comb begin
        viol_next        = clear_i ? '0 : viol_reg;
        first_valid_next = clear_i ? 1'b0 : first_valid_reg;
        first_id_next    = clear_i ? DBG_CHK_R0 : first_id_reg;
        cnt_base         = clear_i ? '0 : cnt_reg;

        if (!first_valid_next && (|rule_hit)) begin
            first_valid_next = 1'b1;
            first_id_next    = dbg_chk_first_rule(rule_hit);
        end
        viol_next = viol_next | rule_hit;

        cnt_sum  = SUM_W'(cnt_base) + SUM_W'(dbg_chk_popcount(rule_hit));
        cnt_next = (cnt_sum > CNT_SAT) ? CNT_W'(CNT_SAT) : CNT_W'(cnt_sum);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            viol_reg        <= '0;
            first_valid_reg <= 1'b0;
            first_id_reg    <= DBG_CHK_R0;
            cnt_reg         <= '0;
        end else begin
            viol_reg        <= viol_next;
            first_valid_reg <= first_valid_next;
            first_id_reg    <= first_id_next;
            cnt_reg         <= cnt_next;
        end
    end

    assign viol_o             = viol_reg;
    assign first_viol_valid_o = first_valid_reg;
    assign first_viol_id_o    = first_id_reg;
    assign viol_cnt_o         = cnt_reg;

endmodule

// File: tb/tb_cv32e40p_dbg_entry_checker.sv
// Directed plus randomized checking of three checker configurations against a
// behavioural model built from the rule definitions.
module tb_cv32e40p_dbg_entry_checker;
    import cv32e40p_pkg::*;

    localparam int MAX_LAT = 4;
    localparam int NI      = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, clr, dm, req, trig, ebi, ebf, wake, sstep, lev, derr;
    ctrl_state_e cs;

    logic [NI-1:0][4:0] viol;
    logic [NI-1:0]      fv;
    logic [NI-1:0][2:0] fid;
    logic [7:0]         cnt_a;
    logic [1:0]         cnt_b;
    logic [7:0]         cnt_c;

    // Model: 0 = default config, 1 = 2-bit counter, 2 = R1 disabled
    logic [4:0] m_en  [NI] = '{5'b11111, 5'b11111, 5'b11101};
    int         m_max [NI] = '{255, 3, 255};
    logic [4:0] m_viol[NI];
    logic       m_fv  [NI];
    int         m_fid [NI];
    int         m_cnt [NI];
    int         run;
    bit         fired;

    int n_cmp, n_mis, cyc;

    cv32e40p_dbg_entry_checker #(.MAX_LAT(MAX_LAT), .CNT_W(8), .RULE_EN(5'b11111)) dut_a (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_i(clr), .ctrl_fsm_cs_i(cs),
        .debug_mode_i(dm), .debug_req_entry_i(req), .trigger_match_i(trig),
        .ebrk_insn_i(ebi), .ebrk_force_debug_mode_i(ebf), .debug_force_wakeup_i(wake),
        .debug_single_step_i(sstep), .data_load_event_i(lev), .data_err_i(derr),
        .viol_o(viol[0]), .first_viol_valid_o(fv[0]), .first_viol_id_o(fid[0]), .viol_cnt_o(cnt_a));

    cv32e40p_dbg_entry_checker #(.MAX_LAT(MAX_LAT), .CNT_W(2), .RULE_EN(5'b11111)) dut_b (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_i(clr), .ctrl_fsm_cs_i(cs),
        .debug_mode_i(dm), .debug_req_entry_i(req), .trigger_match_i(trig),
        .ebrk_insn_i(ebi), .ebrk_force_debug_mode_i(ebf), .debug_force_wakeup_i(wake),
        .debug_single_step_i(sstep), .data_load_event_i(lev), .data_err_i(derr),
        .viol_o(viol[1]), .first_viol_valid_o(fv[1]), .first_viol_id_o(fid[1]), .viol_cnt_o(cnt_b));

    cv32e40p_dbg_entry_checker #(.MAX_LAT(MAX_LAT), .CNT_W(8), .RULE_EN(5'b11101)) dut_c (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_i(clr), .ctrl_fsm_cs_i(cs),
        .debug_mode_i(dm), .debug_req_entry_i(req), .trigger_match_i(trig),
        .ebrk_insn_i(ebi), .ebrk_force_debug_mode_i(ebf), .debug_force_wakeup_i(wake),
        .debug_single_step_i(sstep), .data_load_event_i(lev), .data_err_i(derr),
        .viol_o(viol[2]), .first_viol_valid_o(fv[2]), .first_viol_id_o(fid[2]), .viol_cnt_o(cnt_c));

    function automatic logic [31:0] cnt_of(input int k);
        case (k)
            0:       return 32'(cnt_a);
            1:       return 32'(cnt_b);
            default: return 32'(cnt_c);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("viol%0d", k), 32'(viol[k]), 32'(m_viol[k]));
            chk($sformatf("fvalid%0d", k), 32'(fv[k]), 32'(m_fv[k]));
            chk($sformatf("fid%0d", k), 32'(fid[k]), 32'(m_fid[k]));
            chk($sformatf("cnt%0d", k), cnt_of(k), 32'(m_cnt[k]));
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_viol[k] = '0;
            m_fv[k]   = 1'b0;
            m_fid[k]  = 0;
            m_cnt[k]  = 0;
        end
        run   = 0;
        fired = 1'b0;
    endtask

    task automatic set_idle();
        rst = 1'b0; en = 1'b1; clr = 1'b0; cs = DECODE; dm = 1'b0; req = 1'b0;
        trig = 1'b0; ebi = 1'b0; ebf = 1'b0; wake = 1'b0; sstep = 1'b0;
        lev = 1'b0; derr = 1'b0;
    endtask

    // Advance one clock: update the model from the current inputs, then compare.
    task automatic tick();
        logic [4:0] r;
        logic [4:0] hit;
        logic       taken, ebrk, cause;
        ebrk  = ebi & ebf;
        taken = (cs == DBG_TAKEN_ID) || (cs == DBG_TAKEN_IF);
        cause = trig | ebrk | req;
        r     = '0;
        r[0]  = (cs == DBG_TAKEN_ID) && !dm && !cause;
        r[1]  = (cs == DBG_TAKEN_IF) && !wake && !sstep;
        r[2]  = (cs == DBG_FLUSH) && !derr && !(dm | cause | lev);
        r[4]  = (cs == DBG_TAKEN_ID) && ebi && !ebf && !dm && !cause;
        // Watchdog seen as the length of an unserviced request episode.
        if (!en) begin
            run = 0; fired = 1'b0;
        end else if (run == 0) begin
            if (req && !dm) run = 1;
        end else if (fired) begin
            if (!req || taken) begin run = 0; fired = 1'b0; end
        end else if (taken || !req || dm) begin
            run = 0;
        end else begin
            run++;
            if (run == MAX_LAT) begin r[3] = 1'b1; fired = 1'b1; end
        end
        if (!en) r = '0;
        for (int k = 0; k < NI; k++) begin
            hit = r & m_en[k];
            if (clr) begin
                m_viol[k] = '0; m_fv[k] = 1'b0; m_fid[k] = 0; m_cnt[k] = 0;
            end
            m_viol[k] = m_viol[k] | hit;
            if (!m_fv[k] && hit != 5'b0) begin
                m_fv[k] = 1'b1;
                for (int i = 4; i >= 0; i--) if (hit[i]) m_fid[k] = i;
            end
            m_cnt[k] = m_cnt[k] + $countones(hit);
            if (m_cnt[k] > m_max[k]) m_cnt[k] = m_max[k];
        end
        if (rst) model_reset();
        @(posedge clk);
        #1;
        cyc++;
        check_all();
        $display("cyc=%0d rst=%0b en=%0b clr=%0b cs=%s req=%0b dm=%0b | viol=%b/%b/%b fid=%0d/%0d/%0d cnt=%0d/%0d/%0d",
                 cyc, rst, en, clr, cs.name(), req, dm, viol[0], viol[1], viol[2],
                 fid[0], fid[1], fid[2], cnt_a, cnt_b, cnt_c);
    endtask

    initial begin
        int sel;
        n_cmp = 0; n_mis = 0; cyc = 0;
        set_idle();
        model_reset();
        rst = 1'b1;
        tick();
        tick();
        chk("reset_viol", 32'(viol[0]), 32'd0);
        chk("reset_fvalid", 32'(fv[0]), 32'd0);
        chk("reset_cnt", 32'(cnt_a), 32'd0);
        rst = 1'b0;

        // Justified entry: trigger present
        cs = DBG_TAKEN_ID; trig = 1'b1;
        tick();
        set_idle();
        chk("trig_entry_viol", 32'(viol[0]), 32'd0);
        chk("trig_entry_cnt", 32'(cnt_a), 32'd0);

        // Three unjustified DBG_TAKEN_IF cycles
        cs = DBG_TAKEN_IF;
        repeat (3) tick();
        set_idle();
        chk("r1_flag", 32'(viol[0][1]), 32'd1);
        chk("r1_fid", 32'(fid[0]), 32'd1);
        chk("r1_cnt", 32'(cnt_a), 32'd3);
        chk("r1_masked_viol", 32'(viol[2]), 32'd0);
        chk("r1_masked_cnt", 32'(cnt_c), 32'd0);
        clr = 1'b1; tick(); clr = 1'b0;

        // Request held past MAX_LAT
        req = 1'b1;
        repeat (3) tick();
        chk("wd_early", 32'(viol[0][3]), 32'd0);
        tick();
        chk("wd_fire_viol", 32'(viol[0]), 32'b01000);
        chk("wd_fire_cnt", 32'(cnt_a), 32'd1);
        repeat (2) tick();
        chk("wd_no_refire", 32'(cnt_a), 32'd1);
        req = 1'b0; tick();
        clr = 1'b1; tick(); clr = 1'b0;

        // Same request, serviced on the last allowed cycle
        req = 1'b1;
        repeat (3) tick();
        cs = DBG_TAKEN_ID; tick();
        set_idle();
        repeat (2) tick();
        chk("wd_serviced_viol", 32'(viol[0]), 32'd0);
        chk("wd_serviced_cnt", 32'(cnt_a), 32'd0);

        // Simultaneous R0 and R4
        cs = DBG_TAKEN_ID; ebi = 1'b1;
        tick();
        set_idle();
        chk("multi_fid", 32'(fid[0]), 32'd0);
        chk("multi_cnt", 32'(cnt_a), 32'd2);
        chk("multi_viol", 32'(viol[0]), 32'b10001);
        clr = 1'b1; tick(); clr = 1'b0;

        // Saturation on the 2-bit counter, then clear with a same-cycle violation
        cs = DBG_TAKEN_IF;
        repeat (5) tick();
        chk("sat_cnt", 32'(cnt_b), 32'd3);
        clr = 1'b1; tick();
        chk("clr_same_cnt", 32'(cnt_b), 32'd1);
        chk("clr_same_viol", 32'(viol[1]), 32'b00010);
        set_idle();

        // Checking disabled
        clr = 1'b1; tick();
        set_idle();
        en = 1'b0; cs = DBG_TAKEN_IF; req = 1'b1;
        repeat (8) tick();
        chk("disabled_viol", 32'(viol[0]), 32'd0);
        chk("disabled_cnt", 32'(cnt_a), 32'd0);
        set_idle();

        // Reset in the middle of a pending request
        req = 1'b1;
        repeat (2) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (3) tick();
        req = 1'b0;
        repeat (3) tick();
        chk("rst_mid_viol", 32'(viol[0]), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            rst   = ($urandom_range(0, 199) == 0);
            en    = ($urandom_range(0, 19) != 0);
            clr   = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 5) == 0) req = ~req;
            if ($urandom_range(0, 11) == 0) dm = ~dm;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       cs = DBG_TAKEN_ID;
                1:       cs = DBG_TAKEN_IF;
                2:       cs = DBG_FLUSH;
                3:       cs = IRQ_FLUSH;
                default: cs = DECODE;
            endcase
            trig  = ($urandom_range(0, 2) == 0);
            ebi   = ($urandom_range(0, 2) == 0);
            ebf   = ($urandom_range(0, 2) == 0);
            wake  = ($urandom_range(0, 2) == 0);
            sstep = ($urandom_range(0, 2) == 0);
            lev   = ($urandom_range(0, 2) == 0);
            derr  = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
